if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
IF/ID pipeline register for the 16-bit pipelined core. It sits between instruction fetch and decode. Each clock edge it captures the fetched PC, PC+4 and instruction word and presents them to decode. It supports a stall (hold) for hazard handling and a flush (bubble insert) for taken branches.

Parameters:
- ADDR_W, 16, width of the PC and PC+4 fields.
- INSTR_W, 16, width of the instruction word.
- NOP_INSTR, 16'h0000, instruction value injected on reset and flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  1 = hold current contents (decode not ready).
- flush  in  1  1 = replace contents with a bubble on the next edge.
- valid_in  in  1  fetch stage presents a real instruction.
- pc_in  in  ADDR_W  PC of the fetched instruction.
- pc_plus4_in  in  ADDR_W  sequential next PC from fetch.
- instruction_in  in  INSTR_W  fetched instruction word.
- valid_out  out  1  decode-stage instruction is real.
- pc_out  out  ADDR_W  registered PC.
- pc_plus4_out  out  ADDR_W  registered PC+4.
- instruction_out  out  INSTR_W  registered instruction.

Behaviour:
- All outputs are driven directly from flops; no combinational path from input to output.
- Reset (reset==0): asynchronous. Immediately sets pc_out=0, pc_plus4_out=0, instruction_out=NOP_INSTR and valid_out=0. Reset dominates all other inputs. Outputs stay at these values while reset is low.
- Reset release: synchronous use resumes at the first rising edge where reset==1.
- Reset asserted mid-operation discards any in-flight contents. The first edge after release loads the current inputs.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until the next load.
- Priority at each rising edge (reset high): flush > stall > load.
  - Flush: pc_out=0, pc_plus4_out=0, instruction_out=NOP_INSTR, valid_out=0.
  - Stall (flush==0): all four outputs hold their previous values.
  - Load (flush==0, stall==0): outputs take pc_in, pc_plus4_in, instruction_in and valid_in.
- Simultaneous flush and stall: flush wins, so a bubble is inserted.
- No arithmetic is performed. pc_plus4_in is passed through unchanged; the block does not check that it equals pc_in+4.
- X on inputs during stall or flush must not propagate to the outputs.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds three output ports:
  - stall_cnt [31:0]: counts edges with stall==1 and flush==0.
  - flush_cnt [31:0]: counts edges with flush==1.
  - load_cnt [31:0]: counts edges with a load and valid_in==1.
- Counters are cleared asynchronously by reset and wrap modulo 2^32.
- When the macro is not defined, these ports and their logic do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package if_id_pkg holds:
  - ADDR_W and INSTR_W default constants.
  - NOP_INSTR constant.
  - Typedef if_id_t: packed struct {valid, pc, pc_plus4, instr}.
  - Reset-value constant IF_ID_RST of type if_id_t.
- One sub-module, pipe_reg: a generic width-parameterised flop with async active-low reset, enable and synchronous clear to a parameter value. if_id_reg instantiates it once on the packed struct.
- The perf counters live inline under the macro.

Test Plan:
- Reset then load: hold reset=0 for 10 ns, release. Drive pc_in=0x0004, pc_plus4_in=0x0008, instruction_in=0x1234, valid_in=1. Next edge → outputs 0x0004/0x0008/0x1234, valid_out=1.
- Back-to-back loads: next cycle drive 0x0008/0x000C/0x5678 → outputs update exactly one edge later, with no skipped or duplicated value.
- Async reset mid-operation: pull reset low between edges while outputs are 0x0008/0x000C/0x5678 → outputs go to 0/0/NOP_INSTR and valid 0 without waiting for a clock. After release, 0x0010/0x0014/0x9ABC is captured on the first edge.
- Stall: with outputs at 0x0004/0x0008/0x1234, assert stall for 3 cycles while inputs change to 0x0008/0x000C/0x5678 → outputs unchanged. Deassert → next edge loads 0x0008/0x000C/0x5678.
- Flush priority: assert flush and stall together with inputs 0x0010/0x0014/0x9ABC → outputs 0/0/NOP_INSTR, valid_out=0.
- Perf counters (IF_ID_PERF_CNT_EN defined): 2 stall edges, 1 flush edge, 4 valid loads → stall_cnt=2, flush_cnt=1, load_cnt=4. All three read 0 after an async reset.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and default constants for the IF/ID pipeline register.
package if_id_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic                   valid;
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_ADDR_W-1:0]  pc_plus4;
    logic [DEF_INSTR_W-1:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_RST = '{
    valid:    1'b0,
    pc:       '0,
    pc_plus4: '0,
    instr:    DEF_NOP_INSTR
  };

endpackage

// File: rtl/if_id_reg_pipe_reg.sv
// Generic pipeline flop: async active-low reset, synchronous clear (wins over
// enable), and enable-to-load; reset and clear both return to RST_VAL.
module pipe_reg #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall (hold) and flush (bubble insert).
// Optional performance counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_reg
  import if_id_pkg::*;
#(
  parameter int                  ADDR_W    = DEF_ADDR_W,
  parameter int                  INSTR_W   = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [ADDR_W-1:0]  pc_plus4_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               valid_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic [INSTR_W-1:0] instruction_out
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        load_cnt
`endif
);

  // Local mirror of if_id_t so the field widths follow the module parameters.
  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } stage_t;

  localparam stage_t STAGE_RST = '{
    valid:    1'b0,
    pc:       '0,
    pc_plus4: '0,
    instr:    NOP_INSTR
  };

  stage_t stage_p0;
  stage_t stage_p1;

  assign stage_p0 = '{
    valid:    valid_in,
    pc:       pc_in,
    pc_plus4: pc_plus4_in,
    instr:    instruction_in
  };

  // ---- stage boundary: fetch -> decode ----
  pipe_reg #(
    .DATA_W  ($bits(stage_t)),
    .RST_VAL (STAGE_RST)
  ) u_stage_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (~stall),
    .clr   (flush),
    .d     (stage_p0),
    .q     (stage_p1)
  );

  assign valid_out       = stage_p1.valid;
  assign pc_out          = stage_p1.pc;
  assign pc_plus4_out    = stage_p1.pc_plus4;
  assign instruction_out = stage_p1.instr;

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      if (flush)
        flush_cnt <= flush_cnt + 32'd1;
      if (stall && !flush)
        stall_cnt <= stall_cnt + 32'd1;
      if (!stall && !flush && valid_in)
        load_cnt  <= load_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: the driver queues the expected outputs for
// each edge (or reset assertion) and a separate monitor pops and compares.
module tb_if_id_reg;
  import if_id_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [15:0] pc_in;
  logic [15:0] pc_plus4_in;
  logic [15:0] instruction_in;
  logic        valid_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus4_out;
  logic [15:0] instruction_out;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] load_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    if_id_t exp;
    string  name;
  } exp_item_t;

  exp_item_t sb_q[$];
  logic      drive_done = 1'b0;

  if_id_reg dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .valid_in        (valid_in),
    .pc_in           (pc_in),
    .pc_plus4_in     (pc_plus4_in),
    .instruction_in  (instruction_in),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .instruction_out (instruction_out)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .load_cnt        (load_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic if_id_t mk(input logic v, input logic [15:0] pc,
                                input logic [15:0] pc4, input logic [15:0] ins);
    if_id_t r;
    r.valid    = v;
    r.pc       = pc;
    r.pc_plus4 = pc4;
    r.instr    = ins;
    return r;
  endfunction

  function automatic if_id_t bubble();
    return mk(1'b0, 16'h0000, 16'h0000, 16'h0000);
  endfunction

  task automatic push(input if_id_t e, input string name);
    exp_item_t it;
    it.exp  = e;
    it.name = name;
    sb_q.push_back(it);
  endtask

  // Called at a falling edge: apply inputs and queue the outputs expected
  // after the following rising edge.
  task automatic step(input logic fl, input logic st, input logic v,
                      input logic [15:0] pc, input logic [15:0] pc4,
                      input logic [15:0] ins, input if_id_t e, input string name);
    flush          = fl;
    stall          = st;
    valid_in       = v;
    pc_in          = pc;
    pc_plus4_in    = pc4;
    instruction_in = ins;
    push(e, name);
    @(negedge clk);
  endtask

  // Monitor: wakes on every rising edge or reset assertion.
  initial begin : monitor
    exp_item_t it;
    if_id_t    act;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (sb_q.size() != 0) begin
        it  = sb_q.pop_front();
        act = mk(valid_out, pc_out, pc_plus4_out, instruction_out);
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got v=%b pc=%h pc4=%h ins=%h, required v=%b pc=%h pc4=%h ins=%h",
                   it.name, act.valid, act.pc, act.pc_plus4, act.instr,
                   it.exp.valid, it.exp.pc, it.exp.pc_plus4, it.exp.instr);
        end
      end
    end
  end

  initial begin : driver
    if_id_t a, b, c, d;
    a = mk(1'b1, 16'h0004, 16'h0008, 16'h1234);
    b = mk(1'b1, 16'h0008, 16'h000C, 16'h5678);
    c = mk(1'b1, 16'h0010, 16'h0014, 16'h9ABC);
    d = mk(1'b0, 16'h0020, 16'h0024, 16'hBEEF);

    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
    pc_in = 16'h1111; pc_plus4_in = 16'h2222; instruction_in = 16'h3333;
    #2;
    push(bubble(), "reset_hold");
    @(negedge clk);
    reset = 1'b1;

    step(0, 0, 1, 16'h0004, 16'h0008, 16'h1234, a, "load_first");
    step(0, 0, 1, 16'h0008, 16'h000C, 16'h5678, b, "load_b2b");

    // Async reset between edges, inputs already showing the next word.
    #2;
    pc_in = 16'h0010; pc_plus4_in = 16'h0014; instruction_in = 16'h9ABC;
    push(bubble(), "async_reset_now");
    push(bubble(), "reset_low_edge");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 16'h0010, 16'h0014, 16'h9ABC, c, "load_after_reset");

    step(0, 0, 1, 16'h0004, 16'h0008, 16'h1234, a, "load_a");
    step(0, 1, 1, 16'h0008, 16'h000C, 16'h5678, a, "stall_1");
    step(0, 1, 1, 16'h0008, 16'h000C, 16'h5678, a, "stall_2");
    step(0, 1, 1, 16'h0008, 16'h000C, 16'h5678, a, "stall_3");
    step(0, 0, 1, 16'h0008, 16'h000C, 16'h5678, b, "load_after_stall");
    step(1, 1, 1, 16'h0010, 16'h0014, 16'h9ABC, bubble(), "flush_over_stall");
    step(0, 0, 1, 16'h0004, 16'h0008, 16'h1234, a, "load_after_flush");
    step(0, 1, 1'bx, 16'hxxxx, 16'hxxxx, 16'hxxxx, a, "stall_x_inputs");
    step(1, 0, 1'bx, 16'hxxxx, 16'hxxxx, 16'hxxxx, bubble(), "flush_x_inputs");
    step(0, 0, 0, 16'h0020, 16'h0024, 16'hBEEF, d, "load_invalid");
    flush = 1'b0; stall = 1'b1;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, required 0", sb_q.size());
    end

`ifdef IF_ID_PERF_CNT_EN
    // Since the mid-run reset: stalls 4, flushes 2, valid loads 4.
    checks++;
    if (stall_cnt !== 32'd4) begin
      failures++;
      $display("FAIL stall_cnt: got %0d, required 4", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd2) begin
      failures++;
      $display("FAIL flush_cnt: got %0d, required 2", flush_cnt);
    end
    checks++;
    if (load_cnt !== 32'd4) begin
      failures++;
      $display("FAIL load_cnt: got %0d, required 4", load_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({stall_cnt, flush_cnt, load_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL cnt_reset: got %0d/%0d/%0d, required 0/0/0",
               stall_cnt, flush_cnt, load_cnt);
    end
    reset = 1'b1;
`endif

    drive_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5000;
    if (!drive_done) begin
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
    end
  end

endmodule
